muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, giving the operand and HI/LO register width; legal values are 8..64 and must be even.
REQ-002 SHALL provide port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1 bit: request to issue op this cycle.
REQ-005 SHALL provide port op, input, 3 bits: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; all other codes are no-op.
REQ-006 SHALL provide ports a and b, input, WIDTH bits each: rs and rt operands; MTHI and MTLO use a.
REQ-007 SHALL provide port flush, input, 1 bit: abort any in-flight operation (exception or ERET).
REQ-008 SHALL provide ports hi and lo, output, WIDTH bits each: architectural HI and LO registers.
REQ-009 SHALL provide port busy, output, 1 bit: unit occupied; the ID stage stalls MFHI, MFLO and mul/div ops while it is high.
REQ-010 SHALL provide port done, output, 1 bit: one-cycle pulse in the cycle after hi and lo receive a mul/div result.
REQ-011 SHALL provide port div_zero, output, 1 bit: one-cycle pulse coincident with done when the divisor was 0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIX; busy = (state != IDLE), driven combinationally from the state register.
REQ-013 IDLE: start with op MULT, MULTU, DIV or DIVU SHALL latch the operands, clear the iteration counter and go to CALC.
REQ-014 IDLE: start with MTHI or MTLO SHALL write a into hi or lo on the same edge; the state stays IDLE and done is not pulsed.
REQ-015 CALC SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes) for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL apply sign correction, write hi and lo, assert done on the next cycle and return to IDLE.
REQ-017 Latency: a result is visible on hi and lo WIDTH+2 rising edges after the accepting edge; a new start is accepted on the edge on which done is high.
REQ-018 MULT and MULTU SHALL produce a 2*WIDTH-bit signed or unsigned product, with the upper half in hi and the lower half in lo.
REQ-019 DIV and DIVU SHALL put the quotient in lo and the remainder in hi; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-020 Signed MIN/-1 SHALL give lo = MIN and hi = 0, with no flag.
REQ-021 A divisor of 0 SHALL leave hi and lo unchanged and pulse div_zero with done.
REQ-022 start while busy SHALL be ignored, with no state change.
REQ-023 flush SHALL force IDLE on the next edge, leave hi and lo unchanged and suppress done and div_zero; flush and start in the same cycle means flush wins and start is ignored.
REQ-024 Invalid op codes with start SHALL be ignored.

Reset
REQ-025 On a clock edge with reset=0, the unit SHALL set state=IDLE, hi=0, lo=0, done=0, div_zero=0 and counter=0.
REQ-026 Reset SHALL override start and flush and SHALL discard any in-flight operation.
REQ-027 Outputs SHALL hold their reset values until the first edge with reset=1.

Configuration
REQ-028 Macro MULDIV_DIV_EN defined SHALL enable the divide datapath exactly as in REQ-019 to REQ-021.
REQ-029 Macro MULDIV_DIV_EN undefined SHALL remove the divider logic; DIV and DIVU are then treated as invalid ops (REQ-024), and div_zero is tied to 0.

Verification (WIDTH=32, MULDIV_DIV_EN defined)
REQ-030 MULT a=7, b=0xFFFFFFFD (-3) -> busy high for 34 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, with done pulsed once.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-032 hi=5, lo=9, then DIVU a=100, b=0 -> div_zero and done pulse together, hi=5, lo=9 unchanged.
REQ-033 MULTU a=b=0xFFFFFFFF, with flush at cycle 10 -> busy drops next cycle, no done pulse, hi and lo hold prior values; a second start during busy is ignored.
REQ-034 reset=0 at cycle 5 of a DIV -> next cycle busy=0, hi=lo=0; then MTHI a=0x1234 -> hi=0x1234 after one edge, with busy never asserted.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit.
//   MULT/MULTU use a radix-2 shift-add on operand magnitudes; DIV/DIVU use a
//   radix-2 restoring divide on magnitudes. Each op takes WIDTH CALC cycles,
//   then two FIX cycles: the first applies sign correction, the second
//   commits HI/LO. MTHI/MTLO write directly from IDLE.
//   Optional feature: define MULDIV_DIV_EN to build the divide datapath;
//   without it DIV/DIVU are treated as invalid ops and div_zero is tied low.
//   Handshake: start is sampled only while busy is low; an accepted op
//   produces exactly one done pulse unless flush or reset aborts it.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       dbg_state_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_pulse_q;
    // rem_q: running partial product high half / partial remainder
    // quo_q: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] rem_q, quo_q;
    logic [WIDTH-1:0] opb_q;          // multiplicand or divisor magnitude
    logic             neg_lo_q;       // negate product, or negate quotient
`ifdef MULDIV_DIV_EN
    logic             neg_hi_q;       // negate remainder (dividend sign)
    logic             is_div_q;
    logic             dz_q;
`endif

    // Decoded request and operand magnitudes
    logic             is_mul_op, accept_op, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULDIV_DIV_EN
    logic             is_div_op;
`endif

    // Next values for one datapath step and for the sign-correction stage
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_rem_d, step_quo_d;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     div_shl;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
`endif

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
`ifdef MULDIV_DIV_EN
    assign div_zero    = dz_pulse_q;
`else
    assign div_zero    = 1'b0;
`endif

    // Decode the op and take operand magnitudes for signed ops
    always_comb begin
        is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_DIV_EN
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
        accept_op = is_mul_op || is_div_op;
        signed_op = (op == OP_MULT) || (op == OP_DIV);
`else
        accept_op = is_mul_op;
        signed_op = (op == OP_MULT);
`endif
        a_neg = signed_op && a[WIDTH-1];
        b_neg = signed_op && b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        step_rem_d = mul_sum[WIDTH:1];
        step_quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shl = {rem_q, quo_q[WIDTH-1]};
        div_ge  = (div_shl >= {1'b0, opb_q});
        // when div_ge holds the true difference is below opb_q, so WIDTH bits suffice
        div_sub = div_shl[WIDTH-1:0] - opb_q;
        if (is_div_q) begin
            step_rem_d = div_ge ? div_sub : div_shl[WIDTH-1:0];
            step_quo_d = {quo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    // Sign correction of the raw magnitude result
    always_comb begin
        prod     = {rem_q, quo_q};
        prod_neg = ~prod + 1'b1;
        {fix_hi_d, fix_lo_d} = neg_lo_q ? prod_neg : prod;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            fix_hi_d = neg_hi_q ? (~rem_q + 1'b1) : rem_q;
            fix_lo_d = neg_lo_q ? (~quo_q + 1'b1) : quo_q;
        end
`endif
    end

    // Control FSM with registered HI/LO, done and div_zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            opb_q      <= '0;
            neg_lo_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_hi_q   <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
            if (flush) begin
                // abort: no commit, no pulses, any start this cycle is dropped
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (op == OP_MTHI) begin
                                hi_q <= a;
                            end else if (op == OP_MTLO) begin
                                lo_q <= a;
                            end else if (accept_op) begin
                                rem_q    <= '0;
                                quo_q    <= a_mag;
                                opb_q    <= b_mag;
                                neg_lo_q <= a_neg ^ b_neg;
                                cnt_q    <= '0;
                                state_q  <= S_CALC;
`ifdef MULDIV_DIV_EN
                                is_div_q <= is_div_op;
                                neg_hi_q <= is_div_op ? a_neg : (a_neg ^ b_neg);
                                dz_q     <= is_div_op && (b == '0);
`endif
                            end
                        end
                    end
                    S_CALC: begin
                        rem_q <= step_rem_d;
                        quo_q <= step_quo_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_FIX: begin
                        if (cnt_q == '0) begin
                            // first FIX cycle: apply sign correction in place
                            rem_q <= fix_hi_d;
                            quo_q <= fix_lo_d;
                            cnt_q <= CNT_ONE;
                        end else begin
                            // second FIX cycle: commit and signal completion
`ifdef MULDIV_DIV_EN
                            if (!dz_q) begin
                                hi_q <= rem_q;
                                lo_q <= quo_q;
                            end
                            dz_pulse_q <= dz_q;
`else
                            hi_q <= rem_q;
                            lo_q <= quo_q;
`endif
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
